// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : board_io_ctrl
// Brief    : Switch/button debounce and windowed LED display with manual or
//            timed scrolling. Optional LED-MSB heartbeat: BOARD_IO_HEARTBEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_io_ctrl #(
  parameter int NUM_SW       = 4,
  parameter int NUM_LED      = 4,
  parameter int DATA_W       = 32,
  parameter int CLK_DIV      = 50000,
  parameter int DB_TICKS     = 10,
  parameter int SCROLL_TICKS = 500,
  parameter int HB_TICKS     = 250
) (
  input  logic                   CLOCK_IN,
  input  logic                   RESET,
  input  logic [NUM_SW-1:0]      SWITCH,
  input  logic                   BTN,
  input  logic                   MODE,
  input  logic [DATA_W-1:0]      DISP_DATA,
  output logic [NUM_SW-1:0]      SW_STABLE,
  output logic [NUM_SW-1:0]      SW_RISE,
  output logic [((DATA_W/NUM_LED) > 1 ? $clog2(DATA_W/NUM_LED) : 1)-1:0] WIN,
  output logic                   TICK,
  output logic [NUM_LED-1:0]     LED
);

  localparam int c_NUM_WIN = DATA_W / NUM_LED;
  localparam int c_WIN_W   = (c_NUM_WIN > 1) ? $clog2(c_NUM_WIN) : 1;
  localparam int c_NB      = NUM_SW + 1;
  localparam int c_DIV_W   = $clog2(CLK_DIV);
  localparam int c_DB_W    = $clog2(DB_TICKS + 1);
  localparam int c_SC_W    = $clog2(SCROLL_TICKS + 1);

  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;

  assign w_tick = (r_div == c_DIV_W'(CLK_DIV - 1));
  assign TICK   = w_tick;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Button rides in the MSB so it shares the switch debounce path.
  logic [c_NB-1:0] r_raw_s1, r_raw_s2;
  logic            r_mode_s1, r_mode_s2;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET) begin
      r_raw_s1  <= '0;
      r_raw_s2  <= '0;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_raw_s1  <= {BTN, SWITCH};
      r_raw_s2  <= r_raw_s1;
      r_mode_s1 <= MODE;
      r_mode_s2 <= r_mode_s1;
    end
  end

  logic [c_NB-1:0]   r_stable, r_stable_d;
  logic [c_DB_W-1:0] r_db_cnt [c_NB];
  logic [c_NB-1:0]   w_rise;
  logic              w_btn_rise;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET) begin
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < c_NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < c_NB; i++) begin
        if (r_raw_s2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_db_cnt[i] == c_DB_W'(DB_TICKS - 1)) begin
            r_stable[i] <= r_raw_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign w_rise     = r_stable & ~r_stable_d;
  assign w_btn_rise = w_rise[NUM_SW];
  assign SW_STABLE  = r_stable[NUM_SW-1:0];
  assign SW_RISE    = w_rise[NUM_SW-1:0];

  // Auto event fires the cycle after the count lands on SCROLL_TICKS, which
  // aligns it with a debounced button rise so both can merge into one step.
  logic [c_SC_W-1:0] r_scroll;
  logic              w_auto;
  logic              w_step;

  assign w_auto = r_mode_s2 & (r_scroll == c_SC_W'(SCROLL_TICKS));
  assign w_step = w_btn_rise | w_auto;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET)                  r_scroll <= '0;
    else if (!r_mode_s2 || w_auto) r_scroll <= '0;
    else if (w_tick)             r_scroll <= r_scroll + 1'b1;
  end

  logic [c_WIN_W-1:0] r_win;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET) begin
      r_win <= '0;
    end else if (w_step) begin
      if (r_win == c_WIN_W'(c_NUM_WIN - 1)) r_win <= '0;
      else                                   r_win <= r_win + 1'b1;
    end
  end

  assign WIN = r_win;

  logic [NUM_LED-1:0] w_win_data [c_NUM_WIN];
  logic [NUM_LED-1:0] w_led_sel;
  logic [NUM_LED-1:0] w_led_next;
  logic [NUM_LED-1:0] r_led;

  for (genvar k = 0; k < c_NUM_WIN; k++) begin : g_win
    assign w_win_data[k] = DISP_DATA[k*NUM_LED +: NUM_LED];
  end

  assign w_led_sel = w_win_data[r_win];

`ifdef BOARD_IO_HEARTBEAT_EN
  localparam int c_HB_W = $clog2(HB_TICKS + 1);

  logic [c_HB_W-1:0] r_hb_cnt;
  logic              r_hb;
  logic              w_unused_msb;

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (w_tick) begin
      if (r_hb_cnt == c_HB_W'(HB_TICKS - 1)) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
    end
  end

  assign w_unused_msb = w_led_sel[NUM_LED-1];
  assign w_led_next   = {r_hb, w_led_sel[NUM_LED-2:0]};
`else
  logic w_unused_hb;

  assign w_unused_hb = (HB_TICKS == 0);
  assign w_led_next  = w_led_sel;
`endif

  always_ff @(posedge CLOCK_IN) begin
    if (!RESET) r_led <= '0;
    else        r_led <= w_led_next;
  end

  assign LED = r_led;

endmodule
`default_nettype wire

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board front-end for the lab top level. It debounces NUM_SW slide switches and one push button, and produces clean level and rising-edge outputs. It drives NUM_LED LEDs with a selectable window of a wide DISP_DATA word, stepped manually by the button or automatically on a scroll timer. It sits between the board pins and the core, replacing ad-hoc switch/LED wiring in the top level.

Parameters:
NUM_SW, 4, number of switch inputs
NUM_LED, 4, number of LEDs (window width)
DATA_W, 32, width of DISP_DATA; must be an exact multiple of NUM_LED
CLK_DIV, 50000, clock cycles per TICK (>=2)
DB_TICKS, 10, consecutive TICKs an input must differ from its stable value before it is accepted (>=1)
SCROLL_TICKS, 500, TICKs per automatic window step (>=1)
HB_TICKS, 250, TICKs per heartbeat toggle (optional feature only)

Ports:
CLOCK_IN  input  1  system clock; all logic on its rising edge
RESET  input  1  synchronous, active-low reset
SWITCH  input  NUM_SW  raw asynchronous switch pins
BTN  input  1  raw asynchronous window-step button
MODE  input  1  0 = manual stepping, 1 = auto scroll (synchronised internally)
DISP_DATA  input  DATA_W  value to display; synchronous to CLOCK_IN
SW_STABLE  output  NUM_SW  debounced switch levels
SW_RISE  output  NUM_SW  one-cycle pulse per debounced 0->1 switch edge
WIN  output  clog2(DATA_W/NUM_LED)  current window index (min width 1)
TICK  output  1  one-cycle strobe every CLK_DIV cycles
LED  output  NUM_LED  displayed window

Behaviour:
- Reset (RESET=0 at a clock edge): all outputs 0; all counters, synchronisers, debounce states and the window index cleared. Reset applied mid-debounce or mid-scroll aborts that operation with no residual pulse.
- Tick divider: counter runs 0..CLK_DIV-1 and wraps. TICK=1 in the cycle the counter equals CLK_DIV-1.
- Synchroniser: each of SWITCH, BTN and MODE passes through a 2-flop synchroniser (reset value 0).
- Debounce, per bit of SWITCH and BTN: state is stable level S and count C.
  - Any cycle where sync == S: C <= 0.
  - On TICK where sync != S: C <= C+1. When C+1 == DB_TICKS: S <= sync and C <= 0.
  - A glitch shorter than DB_TICKS ticks never changes S.
- SW_STABLE = S for the switch bits.
- SW_RISE[i] = S[i] & ~S_d[i], where S_d is S delayed one cycle. It is high exactly in the first cycle SW_STABLE[i] reads 1. Falling edges produce no pulse.
- Window stepping: NUM_WIN = DATA_W/NUM_LED. A step event is either a debounced BTN rising edge (any mode) or an auto event.
  - Auto event: MODE_sync=1 and the scroll counter reaches SCROLL_TICKS ticks.
  - Scroll counter counts TICKs only while MODE_sync=1. It clears on auto event, when MODE_sync=0, and on reset.
  - Step: WIN <= WIN+1, wrapping NUM_WIN-1 -> 0.
  - Button and auto event in the same cycle: single increment.
  - NUM_WIN=1: WIN stays 0.
- LED: registered; LED <= DISP_DATA[WIN*NUM_LED +: NUM_LED] every cycle.
  - One cycle latency from a DISP_DATA or WIN change to LED.
  - WIN and LED update on the same edge using the old WIN, so LED reflects a new WIN one cycle after WIN changes.
- Switch latency: a clean transition appears on SW_STABLE 2 sync cycles plus DB_TICKS ticks later. Bound: between 2+(DB_TICKS-1)*CLK_DIV+1 and 2+DB_TICKS*CLK_DIV cycles.

Optional Feature:
BOARD_IO_HEARTBEAT_EN
- Defined: LED[NUM_LED-1] is a heartbeat flop instead of the data bit. It resets to 0 and toggles every HB_TICKS ticks (own counter, cleared on reset). LED[NUM_LED-2:0] are unchanged.
- Undefined: no heartbeat logic; all LED bits show data. HB_TICKS is unused.

Test Plan:
Use CLK_DIV=4, DB_TICKS=3, DATA_W=16, NUM_LED=4, SCROLL_TICKS=5; reset held low 5 cycles, then RESET=1.
- Glitch: SWITCH[1]=1 for 6 cycles, then 0 -> SW_STABLE stays 4'b0000 and SW_RISE never asserts.
- Clean press: SWITCH=4'b0101 held -> SW_STABLE becomes 4'b0101 within 11..14 cycles. SW_RISE=4'b0101 for exactly one cycle. Release -> SW_STABLE returns to 0 with no SW_RISE pulse.
- Manual stepping: MODE=0, DISP_DATA=16'hA5C3 -> LED=4'h3.
  - Successive debounced BTN presses -> WIN 1,2,3,0 and LED 4'hC,4'h5,4'hA,4'h3.
- Auto scroll: MODE=1 -> WIN increments every 20 cycles and wraps 3->0.
  - BTN rise coinciding with an auto event -> WIN advances by 1 only.
  - MODE=0 -> WIN frozen.
- Reset mid-operation: RESET=0 for one edge during a pending debounce with WIN=2 -> all outputs 0, WIN=0, and no SW_RISE pulse after RESET returns to 1.
- With BOARD_IO_HEARTBEAT_EN and HB_TICKS=2: LED[3] toggles every 8 cycles; LED[2:0] equal the data bits.
